// File: rtl/mem_pkg.sv
// mem_pkg
//   Shared encodings and helpers for the data-memory bridge: access size codes,
//   bridge FSM state encoding, and byte-mask helpers used by mem_bridge and
//   mem_lane_align.
//   Related build macro: MEM_BRIDGE_MISALIGN_EN (consumed by mem_bridge).
package mem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Byte-lane mask of an access starting at lane 0; illegal size gives 0.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    size_mask = 4'h1;
         SZ_H:    size_mask = 4'h3;
         SZ_W:    size_mask = 4'hF;
         default: size_mask = 4'h0;
      endcase
   endfunction

   // Number of bytes moved by an access; illegal size gives 0.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_B:    size_bytes = 3'd1;
         SZ_H:    size_bytes = 3'd2;
         SZ_W:    size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

   // Expand a 4-bit byte mask into a 32-bit bit mask.
   function automatic logic [31:0] lane_bits(input logic [3:0] m);
      lane_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational byte-lane steering for the memory bridge.
//   Ports:
//     off    in  2   byte offset within the word (addr[1:0])
//     mask   in  4   access byte mask at lane 0 (1, 3 or F)
//     beat   in  1   0 = first word of the access, 1 = following word
//     wdata  in  32  right-aligned store data
//     r0     in  32  read data of the first word
//     r1     in  32  read data of the following word (0 when not split)
//     we     out 4   byte write enables for the selected beat
//     wd     out 32  lane-positioned write data for the selected beat
//     rdata  out 32  load data, right-aligned and zero-filled
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [3:0]  mask,
   input  logic        beat,
   input  logic [31:0] wdata,
   input  logic [31:0] r0,
   input  logic [31:0] r1,
   output logic [3:0]  we,
   output logic [31:0] wd,
   output logic [31:0] rdata
);

   logic [4:0]  sh;
   logic [7:0]  we_wide;
   logic [63:0] wd_wide;
   logic [63:0] rd_wide;

   // Shifting into a double-width vector puts the first-word part in the low
   // half and the spill into the next word in the high half, so one shift
   // serves both beats.
   always_comb begin
      sh      = {off, 3'b000};
      we_wide = {4'b0000, mask} << off;
      wd_wide = {32'h0, wdata} << sh;
      rd_wide = {r1, r0} >> sh;
      we      = beat ? we_wide[7:4]  : we_wide[3:0];
      wd      = beat ? wd_wide[63:32] : wd_wide[31:0];
      rdata   = rd_wide[31:0] & lane_bits(mask);
   end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge
//   Data-memory bridge between the CPU load/store port and a 32-bit word RAM
//   with byte write enables and one-cycle read latency. One request in flight;
//   load data is returned right-aligned and zero-filled.
//   Build macro MEM_BRIDGE_MISALIGN_EN: when defined, accesses crossing a word
//   boundary run as two RAM beats; when undefined, any misaligned access is
//   rejected with rsp_err and the second-beat logic is not built.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     req_valid/req_ready   request handshake
//     req_we, req_size      store flag, size (00 B, 01 H, 10 W, 11 illegal)
//     req_addr, req_wdata   byte address, right-aligned store data
//     rsp_valid, rsp_err    one-cycle completion pulse and error flag
//     rsp_rdata             load data, held until the next response
//     ram_en, ram_we        RAM access strobe and byte write enables
//     ram_addr, ram_wdata   RAM word index and lane-positioned write data
//     ram_rdata             RAM read data, valid the cycle after ram_en
module mem_bridge
   import mem_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-3:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int WORD_W = ADDR_W - 2;

   state_t              state_q, state_d;
   logic                we_q;
   logic [1:0]          off_q;
   logic [3:0]          mask_q;
   logic [WORD_W-1:0]   word_q;
   logic [31:0]         wdata_q;
   logic                err_q;
   logic [31:0]         rdata_q;

   logic                accept;
   logic                req_hi_bad;
   logic                req_misalign;
   logic                req_err;
   logic [31:0]         r0, r1;
   logic [3:0]          lane_we;
   logic [31:0]         lane_wd;
   logic [31:0]         lane_rd;

   assign req_ready  = (state_q == IDLE) & ~reset;
   assign accept     = req_valid & req_ready;
   assign req_hi_bad = (req_addr >> ADDR_W) != 32'h0;

`ifdef MEM_BRIDGE_MISALIGN_EN
   logic                split_q;
   logic [31:0]         r0_q;
   logic                req_split;
   logic                req_last;

   assign req_split    = ({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
   assign req_last     = &req_addr[ADDR_W-1:2];
   // A split access on the last word would need word 0; reject instead of wrapping.
   assign req_misalign = req_split & req_last;
   // Beat 0 data arrives during BEAT1; beat 1 data arrives live during RESP.
   assign r0 = split_q ? r0_q : ram_rdata;
   assign r1 = split_q ? ram_rdata : 32'h0;

   always_ff @(posedge clk) begin
      if (accept) split_q <= req_split;
      if (state_q == BEAT1) r0_q <= ram_rdata;
   end
`else
   logic [1:0]          req_amask;

   assign req_amask    = (req_size == SZ_W) ? 2'b11 :
                         (req_size == SZ_H) ? 2'b01 : 2'b00;
   assign req_misalign = (req_addr[1:0] & req_amask) != 2'b00;
   assign r0 = ram_rdata;
   assign r1 = 32'h0;
`endif

   assign req_err = (req_size == 2'b11) | req_hi_bad | req_misalign;

   mem_lane_align u_align (
      .off   (off_q),
      .mask  (mask_q),
      .beat  (state_q == BEAT1),
      .wdata (wdata_q),
      .r0    (r0),
      .r1    (r1),
      .we    (lane_we),
      .wd    (lane_wd),
      .rdata (lane_rd)
   );

   // Request latch: the bridge works only from this copy once accepted.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         off_q   <= req_addr[1:0];
         mask_q  <= size_mask(req_size);
         word_q  <= req_addr[ADDR_W-1:2];
         wdata_q <= req_wdata;
         err_q   <= req_err;
      end
   end

   // State register and held response data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == RESP) rdata_q <= rsp_rdata;
      end
   end

   always_comb begin
      state_d   = state_q;
      ram_en    = 1'b0;
      ram_we    = 4'h0;
      ram_addr  = '0;
      ram_wdata = 32'h0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) state_d = req_err ? RESP : BEAT0;
         end
         BEAT0: begin
`ifdef MEM_BRIDGE_MISALIGN_EN
            state_d = split_q ? BEAT1 : RESP;
`else
            state_d = RESP;
`endif
            ram_en   = 1'b1;
            ram_addr = word_q;
            if (we_q) begin
               ram_we    = lane_we;
               ram_wdata = lane_wd;
            end
         end
`ifdef MEM_BRIDGE_MISALIGN_EN
         BEAT1: begin
            state_d  = RESP;
            ram_en   = 1'b1;
            ram_addr = word_q + {{(WORD_W-1){1'b0}}, 1'b1};
            if (we_q) begin
               ram_we    = lane_we;
               ram_wdata = lane_wd;
            end
         end
`endif
         RESP: begin
            state_d   = IDLE;
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (err_q)      rsp_rdata = 32'h0;
            else if (!we_q) rsp_rdata = lane_rd;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

   localparam int ADDR_W = 16;
`ifdef MEM_BRIDGE_MISALIGN_EN
   localparam logic [31:0] W40 = 32'h3344BEEF;
`else
   localparam logic [31:0] W40 = 32'hAAADBEEF;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_err;
   logic [31:0]       rsp_rdata;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-3:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_bridge #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Word RAM model: byte enables, one-cycle read latency.
   logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
   logic        mem_clr;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < (1 << (ADDR_W-2)); i++) mem[i] <= 32'h0;
         ram_rdata <= 32'h0;
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= mem[ram_addr];
      end
   end

   // Per-cycle capture of outputs in cycles T+1..T+4 after an accept at T.
   logic              c_rdy;
   logic [4:1]        c_en, c_rv, c_err;
   logic [3:0]        c_we   [1:4];
   logic [ADDR_W-3:0] c_addr [1:4];
   logic [31:0]       c_wd   [1:4];
   logic [31:0]       c_rd   [1:4];

   task automatic run_req(input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = d;
      #1 c_rdy = req_ready;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         #1;
         c_en[k] = ram_en; c_we[k] = ram_we; c_addr[k] = ram_addr; c_wd[k] = ram_wdata;
         c_rv[k] = rsp_valid; c_err[k] = rsp_err; c_rd[k] = rsp_rdata;
         if (k == 1) begin
            // Busy-period garbage on the request bus must not disturb the access.
            req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b exp 0", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      n_cmp++; if (ram_en !== 1'b0) begin n_bad++; $display("FAIL reset_ram_en got %b exp 0", ram_en); end
      n_cmp++; if (ram_we !== 4'h0) begin n_bad++; $display("FAIL reset_ram_we got %h exp 0", ram_we); end
      n_cmp++; if (ram_addr !== 14'h0) begin n_bad++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
      n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
      reset = 1'b0; mem_clr = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_word;
      run_req(1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
      n_cmp++; if (c_rdy !== 1'b1) begin n_bad++; $display("FAIL sw_ready got %b exp 1", c_rdy); end
      n_cmp++; if ({c_en[1], c_we[1], c_addr[1], c_wd[1]} !== {1'b1, 4'hF, 14'h40, 32'hDEADBEEF}) begin
         n_bad++; $display("FAIL sw_beat0 got en=%b we=%h addr=%h wd=%h exp en=1 we=f addr=0040 wd=deadbeef",
                           c_en[1], c_we[1], c_addr[1], c_wd[1]); end
      n_cmp++; if ({c_rv[1], c_rv[2], c_err[2], c_en[2]} !== 4'b0100) begin
         n_bad++; $display("FAIL sw_resp got rv1=%b rv2=%b err=%b en2=%b exp 0 1 0 0", c_rv[1], c_rv[2], c_err[2], c_en[2]); end
      n_cmp++; if (c_rd[2] !== 32'h0) begin n_bad++; $display("FAIL sw_rdata_held got %h exp 0", c_rd[2]); end
      run_req(1'b0, 2'b10, 32'h100, 32'h0);
      n_cmp++; if ({c_en[1], c_we[1], c_addr[1]} !== {1'b1, 4'h0, 14'h40}) begin
         n_bad++; $display("FAIL lw_beat0 got en=%b we=%h addr=%h exp en=1 we=0 addr=0040", c_en[1], c_we[1], c_addr[1]); end
      n_cmp++; if ({c_rv[2], c_err[2], c_rd[2]} !== {2'b10, 32'hDEADBEEF}) begin
         n_bad++; $display("FAIL lw_resp got rv=%b err=%b rd=%h exp rv=1 err=0 rd=deadbeef", c_rv[2], c_err[2], c_rd[2]); end
   endtask

   task automatic test_byte_half;
      run_req(1'b1, 2'b00, 32'h103, 32'h123456AA);
      n_cmp++; if ({c_en[1], c_we[1], c_wd[1]} !== {1'b1, 4'b1000, 32'hAA000000}) begin
         n_bad++; $display("FAIL sb_beat0 got en=%b we=%b wd=%h exp en=1 we=1000 wd=aa000000", c_en[1], c_we[1], c_wd[1]); end
      n_cmp++; if ({c_rv[2], c_rd[2]} !== {1'b1, 32'hDEADBEEF}) begin
         n_bad++; $display("FAIL sb_rdata_held got rv=%b rd=%h exp rv=1 rd=deadbeef", c_rv[2], c_rd[2]); end
      run_req(1'b0, 2'b00, 32'h103, 32'h0);
      n_cmp++; if ({c_rv[2], c_rd[2]} !== {1'b1, 32'h000000AA}) begin
         n_bad++; $display("FAIL lb_resp got rv=%b rd=%h exp rv=1 rd=000000aa", c_rv[2], c_rd[2]); end
      run_req(1'b0, 2'b01, 32'h102, 32'h0);
      n_cmp++; if ({c_rv[2], c_rd[2]} !== {1'b1, 32'h0000AAAD}) begin
         n_bad++; $display("FAIL lh_resp got rv=%b rd=%h exp rv=1 rd=0000aaad", c_rv[2], c_rd[2]); end
   endtask

   task automatic test_misalign;
      run_req(1'b1, 2'b10, 32'h102, 32'h11223344);
`ifdef MEM_BRIDGE_MISALIGN_EN
      n_cmp++; if ({c_en[1], c_addr[1], c_we[1], c_wd[1]} !== {1'b1, 14'h40, 4'b1100, 32'h33440000}) begin
         n_bad++; $display("FAIL split_sw_beat0 got en=%b addr=%h we=%b wd=%h exp 1 0040 1100 33440000",
                           c_en[1], c_addr[1], c_we[1], c_wd[1]); end
      n_cmp++; if ({c_en[2], c_addr[2], c_we[2], c_wd[2]} !== {1'b1, 14'h41, 4'b0011, 32'h00001122}) begin
         n_bad++; $display("FAIL split_sw_beat1 got en=%b addr=%h we=%b wd=%h exp 1 0041 0011 00001122",
                           c_en[2], c_addr[2], c_we[2], c_wd[2]); end
      n_cmp++; if ({c_rv[2], c_rv[3], c_err[3]} !== 3'b010) begin
         n_bad++; $display("FAIL split_sw_resp got rv2=%b rv3=%b err=%b exp 0 1 0", c_rv[2], c_rv[3], c_err[3]); end
      run_req(1'b0, 2'b10, 32'h102, 32'h0);
      n_cmp++; if ({c_rv[2], c_rv[3], c_rd[3]} !== {2'b01, 32'h11223344}) begin
         n_bad++; $display("FAIL split_lw_resp got rv2=%b rv3=%b rd=%h exp 0 1 11223344", c_rv[2], c_rv[3], c_rd[3]); end
`else
      n_cmp++; if ({c_rv[1], c_err[1], c_rd[1]} !== {2'b11, 32'h0}) begin
         n_bad++; $display("FAIL misalign_err got rv=%b err=%b rd=%h exp 1 1 00000000", c_rv[1], c_err[1], c_rd[1]); end
      n_cmp++; if (c_en !== 4'b0000) begin n_bad++; $display("FAIL misalign_no_ram got en=%b exp 0000", c_en); end
      run_req(1'b0, 2'b01, 32'h101, 32'h0);
      n_cmp++; if ({c_rv[1], c_err[1], c_en} !== {2'b11, 4'b0000}) begin
         n_bad++; $display("FAIL misalign_lh got rv=%b err=%b en=%b exp 1 1 0000", c_rv[1], c_err[1], c_en); end
`endif
   endtask

   task automatic test_errors;
      run_req(1'b0, 2'b10, 32'h00010000, 32'h0);
      n_cmp++; if ({c_rv[1], c_err[1], c_rd[1]} !== {2'b11, 32'h0}) begin
         n_bad++; $display("FAIL range_err got rv=%b err=%b rd=%h exp 1 1 00000000", c_rv[1], c_err[1], c_rd[1]); end
      n_cmp++; if (c_en !== 4'b0000) begin n_bad++; $display("FAIL range_no_ram got en=%b exp 0000", c_en); end
      run_req(1'b0, 2'b10, 32'h100, 32'h0);
      n_cmp++; if (c_rd[2] !== W40) begin n_bad++; $display("FAIL relaod_w40 got %h exp %h", c_rd[2], W40); end
      run_req(1'b0, 2'b11, 32'h0, 32'h0);
      n_cmp++; if ({c_rv[1], c_err[1], c_rd[1], c_en} !== {2'b11, 32'h0, 4'b0000}) begin
         n_bad++; $display("FAIL size11_err got rv=%b err=%b rd=%h en=%b exp 1 1 00000000 0000",
                           c_rv[1], c_err[1], c_rd[1], c_en); end
      run_req(1'b0, 2'b01, 32'h0000FFFF, 32'h0);
      n_cmp++; if ({c_rv[1], c_err[1], c_en} !== {2'b11, 4'b0000}) begin
         n_bad++; $display("FAIL lastword_err got rv=%b err=%b en=%b exp 1 1 0000", c_rv[1], c_err[1], c_en); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_wdata = 32'hCAFEF00D;
`ifdef MEM_BRIDGE_MISALIGN_EN
      req_addr = 32'h202;
`else
      req_addr = 32'h200;
`endif
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      n_cmp++; if ({ram_en, ram_addr} !== {1'b1, 14'h80}) begin
         n_bad++; $display("FAIL mid_beat0 got en=%b addr=%h exp 1 0080", ram_en, ram_addr); end
`ifdef MEM_BRIDGE_MISALIGN_EN
      @(negedge clk);
      #1;
      n_cmp++; if ({ram_en, ram_addr} !== {1'b1, 14'h81}) begin
         n_bad++; $display("FAIL mid_beat1 got en=%b addr=%h exp 1 0081", ram_en, ram_addr); end
`endif
      reset = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if ({rsp_valid, ram_en, req_ready} !== 3'b000) begin
         n_bad++; $display("FAIL mid_reset got rv=%b en=%b rdy=%b exp 0 0 0", rsp_valid, ram_en, req_ready); end
      reset = 1'b0;
      #1;
      n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin
         n_bad++; $display("FAIL mid_release got rdy=%b rv=%b exp 1 0", req_ready, rsp_valid); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h100; req_wdata = 32'h0;
      for (int k = 0; k < 9; k++) begin
         #1;
         n_cmp++; if (req_ready !== (k % 3 == 0)) begin
            n_bad++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, req_ready, (k % 3 == 0)); end
         n_cmp++; if (rsp_valid !== (k % 3 == 2)) begin
            n_bad++; $display("FAIL b2b_rsp_valid[%0d] got %b exp %b", k, rsp_valid, (k % 3 == 2)); end
         if (k % 3 == 2) begin
            n_cmp++; if (rsp_rdata !== W40) begin
               n_bad++; $display("FAIL b2b_rdata[%0d] got %h exp %h", k, rsp_rdata, W40); end
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   initial begin
      test_reset;
      test_word;
      test_byte_half;
      test_misalign;
      test_errors;
      test_reset_mid;
      test_back_to_back;
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no summary exp summary within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
